// File: rtl/stack_alu_pkg.sv
// -----------------------------------------------------------------------------
// stack_alu_pkg
// Shared definitions for the stack-based ALU, its RPN sequencer and their
// benches: ALU opcode encodings, the sequencer state encoding, and the helper
// that sizes the shadow depth counter for a given stack capacity.
// -----------------------------------------------------------------------------
package stack_alu_pkg;

    // ALU opcodes (3 bits). NOP is driven whenever no operation is requested.
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    // Sequencer states. S_IDLE is encoded as zero so the debug state output
    // reads 0 while reset is asserted, like every other output.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,  // accepting a token
        S_ISSUE    = 3'd1,  // one-cycle ALU strobe for the latched token
        S_WAIT     = 3'd2,  // waiting for alu_success of PUSH/ADD/MUL
        S_POP      = 3'd3,  // first pop of the result (or skip if empty)
        S_POP_WAIT = 3'd4,  // waiting for alu_success of a POP
        S_DRAIN    = 3'd5,  // further pops that discard leftover entries
        S_DONE     = 3'd6   // result presented until res_ready
    } seq_state_e;

    // Width of a counter that must hold values 0..max_size inclusive.
    function automatic int depth_width(input int max_size);
        return $clog2(max_size + 1);
    endfunction

endpackage

// File: rtl/stack_seq_watchdog.sv
// -----------------------------------------------------------------------------
// stack_seq_watchdog
// Counts the cycles the sequencer spends waiting for alu_success and flags
// when TIMEOUT consecutive waiting cycles pass without it. Only instantiated
// by stack_alu_rpn_sequencer when STACK_SEQ_TIMEOUT_EN is defined.
//
// Parameters:
//   TIMEOUT    number of waiting cycles allowed before expired_o fires (>= 1)
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   clear_i    in   restart the count (asserted while an op is being issued)
//   start_i    in   count this cycle (asserted while waiting for the ALU)
//   expired_o  out  this is the TIMEOUT-th waiting cycle without success
// -----------------------------------------------------------------------------
module stack_seq_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic start_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count equals the number of waiting cycles already elapsed, so the
    // TIMEOUT-th waiting cycle is the one that sees TIMEOUT-1.
    assign expired_o = start_i && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (start_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stack_alu_rpn_sequencer.sv
// -----------------------------------------------------------------------------
// stack_alu_rpn_sequencer
// Upstream feeder for the stack-based ALU. Accepts an RPN token stream
// (signed operands, ADD, MUL) and turns every token into a single-cycle ALU
// opcode strobe, waiting for alu_success after each. At the end of an
// expression it pops the result, drains any leftover entries and presents
// result, sticky overflow and error. A shadow depth count guarantees the ALU
// stack is never underflowed or overfilled; all arithmetic happens in the ALU.
//
// Optional feature: define STACK_SEQ_TIMEOUT_EN to bound every wait for
// alu_success to TIMEOUT cycles (stack_seq_watchdog). Without it the
// sequencer waits indefinitely.
//
// Parameters:
//   N         operand/result width (matches the ALU)
//   MAX_SIZE  ALU stack capacity (matches the ALU)
//   TIMEOUT   cycles allowed per ALU response (only with STACK_SEQ_TIMEOUT_EN)
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   tok_valid/ready   token handshake; tok_is_op, tok_last, tok_data payload
//                     (operator code in tok_data[0]: 0=ADD, 1=MUL)
//   alu_opcode        ALU opcode, NOP when idle; alu_input_data valid with PUSH
//   alu_output_data, alu_overflow, alu_success   ALU responses
//   res_valid/ready   result handshake; res_data, res_overflow, res_error
//   dbg_state         current FSM state
//   dbg_depth         shadow ALU stack depth
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and payload stable until the transfer;
// ready never depends on valid. tok_ready is high only in S_IDLE (and low
// while reset is asserted); res_valid is high only in S_DONE and the result
// stays stable until res_ready is seen.
// -----------------------------------------------------------------------------
module stack_alu_rpn_sequencer
    import stack_alu_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_SIZE = 1024,
    parameter int TIMEOUT  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tok_valid,
    output logic                               tok_ready,
    input  logic                               tok_is_op,
    input  logic                               tok_last,
    input  logic [N-1:0]                       tok_data,
    output logic [2:0]                         alu_opcode,
    output logic [N-1:0]                       alu_input_data,
    input  logic [N-1:0]                       alu_output_data,
    input  logic                               alu_overflow,
    input  logic                               alu_success,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [N-1:0]                       res_data,
    output logic                               res_overflow,
    output logic                               res_error,
    output seq_state_e                         dbg_state,
    output logic [depth_width(MAX_SIZE)-1:0]   dbg_depth
);

    localparam int               DW        = depth_width(MAX_SIZE);
    localparam logic [DW-1:0]    DEPTH_MAX = DW'(MAX_SIZE);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seq_state_e     state_q,     state_d;
    logic [DW-1:0]  depth_q,     depth_d;
    logic           tok_is_op_q, tok_is_op_d;
    logic           tok_last_q,  tok_last_d;
    logic [N-1:0]   tok_data_q,  tok_data_d;
    logic           err_q,       err_d;
    logic           ovf_q,       ovf_d;
    logic [N-1:0]   res_q,       res_d;
    logic           popped_q,    popped_d;   // first (result) pop completed

    logic           wd_clear;
    logic           wd_start;
    logic           wd_expired;

    logic           stack_full;
    logic           stack_short;
    logic           tok_rejected;

    assign stack_full   = (depth_q == DEPTH_MAX);
    assign stack_short  = (depth_q < DW'(2));
    // Once an error is recorded, the rest of the expression is consumed
    // without touching the ALU, so the drain sees a consistent stack.
    assign tok_rejected = err_q
                        || (!tok_is_op_q && stack_full)
                        || ( tok_is_op_q && stack_short);

    assign dbg_state = state_q;
    assign dbg_depth = depth_q;

    // ------------------------------------------------------------------
    // Response watchdog (optional)
    // ------------------------------------------------------------------
`ifdef STACK_SEQ_TIMEOUT_EN
    stack_seq_watchdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wd_clear),
        .start_i   (wd_start),
        .expired_o (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^{wd_clear, wd_start, TIMEOUT};
`endif

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        depth_d        = depth_q;
        tok_is_op_d    = tok_is_op_q;
        tok_last_d     = tok_last_q;
        tok_data_d     = tok_data_q;
        err_d          = err_q;
        ovf_d          = ovf_q;
        res_d          = res_q;
        popped_d       = popped_q;

        tok_ready      = 1'b0;
        alu_opcode     = OP_NOP;
        alu_input_data = '0;
        res_valid      = 1'b0;
        res_data       = '0;
        res_overflow   = 1'b0;
        res_error      = 1'b0;
        wd_clear       = 1'b0;
        wd_start       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Gated by rst so ready reads 0 while reset is held.
                tok_ready = rst;
                if (tok_valid) begin
                    tok_is_op_d = tok_is_op;
                    tok_last_d  = tok_last;
                    tok_data_d  = tok_data;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                wd_clear = 1'b1;
                if (tok_rejected) begin
                    err_d   = 1'b1;
                    state_d = tok_last_q ? S_POP : S_IDLE;
                end else begin
                    if (tok_is_op_q) begin
                        alu_opcode = tok_data_q[0] ? OP_MUL : OP_ADD;
                    end else begin
                        alu_opcode     = OP_PUSH;
                        alu_input_data = tok_data_q;
                    end
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                wd_start = 1'b1;
                if (alu_success) begin
                    // PUSH grows the stack by one; ADD/MUL take two, leave one.
                    depth_d = tok_is_op_q ? (depth_q - DW'(1)) : (depth_q + DW'(1));
                    ovf_d   = ovf_q | alu_overflow;
                    state_d = tok_last_q ? S_POP : S_IDLE;
                end else if (wd_expired) begin
                    // No response: the op is treated as not having happened.
                    err_d   = 1'b1;
                    state_d = tok_last_q ? S_POP : S_IDLE;
                end
            end

            S_POP: begin
                wd_clear = 1'b1;
                // A well-formed expression leaves exactly one entry.
                if (depth_q != DW'(1)) begin
                    err_d = 1'b1;
                end
                if (depth_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    alu_opcode = OP_POP;
                    state_d    = S_POP_WAIT;
                end
            end

            S_POP_WAIT: begin
                wd_start = 1'b1;
                if (alu_success) begin
                    depth_d  = depth_q - DW'(1);
                    popped_d = 1'b1;
                    if (!popped_q) begin
                        res_d = alu_output_data;
                    end
                    state_d = (depth_q == DW'(1)) ? S_DONE : S_DRAIN;
                end else if (wd_expired) begin
                    // Depth is left as is; retrying an unresponsive ALU
                    // would never finish, so the result is reported now.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DRAIN: begin
                wd_clear   = 1'b1;
                alu_opcode = OP_POP;
                state_d    = S_POP_WAIT;
            end

            S_DONE: begin
                res_valid    = 1'b1;
                res_data     = err_q ? '0 : res_q;
                res_overflow = ovf_q;
                res_error    = err_q;
                if (res_ready) begin
                    err_d    = 1'b0;
                    ovf_d    = 1'b0;
                    res_d    = '0;
                    popped_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            depth_q     <= '0;
            tok_is_op_q <= 1'b0;
            tok_last_q  <= 1'b0;
            tok_data_q  <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            res_q       <= '0;
            popped_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            tok_is_op_q <= tok_is_op_d;
            tok_last_q  <= tok_last_d;
            tok_data_q  <= tok_data_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            res_q       <= res_d;
            popped_q    <= popped_d;
        end
    end

endmodule
